// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit controller.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_frame_cnt.sv
// Frame position counter for the I2S transmitter: counts 0..2*pdata_width-1 while running,
// and reports the upper-half flag and the last-cycle-of-frame strobe.
module i2s_frame_cnt #(
    parameter int pdata_width = 32,
    parameter int CNT_W       = $clog2(2 * pdata_width)
) (
    input  logic sclk_in,
    input  logic rst,
    input  logic run,
    output logic half,
    output logic boundary
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2 * pdata_width - 1);
    localparam logic [CNT_W-1:0] HALFP = CNT_W'(pdata_width);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap     = (cnt == LAST);
    assign half     = (cnt >= HALFP);
    assign boundary = run && wrap;

    // Held at zero outside RUN so the first running cycle is always position 0.
    always_ff @(posedge sclk_in) begin
        if (rst || !run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: single-entry sample buffer, frame-aligned start/stop and underrun tracking.
// Build option I2S_TX_CTRL_REPEAT_EN: on underrun, repeat the previous pair instead of sending zeros.
//
// state | meaning
// IDLE  | stopped, counter at 0, no pairs accepted
// PRIME | collecting the first pair before the first frame
// RUN   | streaming frames, refilling the buffer once per frame
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int pdata_width = 32
) (
    input  logic                      sclk_in,
    input  logic                      rst,
    input  logic                      enable_in,
    input  logic                      s_valid_in,
    output logic                      s_ready_out,
    input  logic [pdata_width-1:0]    s_ldata_in,
    input  logic [pdata_width-1:0]    s_rdata_in,
    output logic                      lrck_out,
    output logic [pdata_width-1:0]    pldata_out,
    output logic [pdata_width-1:0]    prdata_out,
    output logic                      underrun_out,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_out
);

    state_t                    state_q, state_d;
    logic                      buf_full_q, buf_full_d;
    logic [pdata_width-1:0]    buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [pdata_width-1:0]    pl_d, pr_d;
    logic                      ready_d, lrck_d, urun_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_d;
    logic                      accept, half, boundary;

    i2s_frame_cnt #(.pdata_width(pdata_width)) u_frame_cnt (
        .sclk_in  (sclk_in),
        .rst      (rst),
        .run      (state_q == RUN),
        .half     (half),
        .boundary (boundary)
    );

    assign accept = s_valid_in && s_ready_out;

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        pl_d       = pldata_out;
        pr_d       = prdata_out;
        urun_d     = 1'b0;
        ucnt_d     = underrun_cnt_out;

        case (state_q)
            IDLE: begin
                buf_full_d = 1'b0;
                if (enable_in) state_d = PRIME;
            end
            PRIME: begin
                if (!enable_in) begin
                    state_d    = IDLE;
                    buf_full_d = 1'b0;
                end else if (buf_full_q) begin
                    state_d    = RUN;
                    pl_d       = buf_l_q;
                    pr_d       = buf_r_q;
                    buf_full_d = 1'b0;
                end else if (accept) begin
                    buf_full_d = 1'b1;
                    buf_l_d    = s_ldata_in;
                    buf_r_d    = s_rdata_in;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (!enable_in) begin
                        // Stopping: outputs keep the last pair, any buffered pair is dropped.
                        state_d    = IDLE;
                        buf_full_d = 1'b0;
                    end else if (buf_full_q) begin
                        pl_d       = buf_l_q;
                        pr_d       = buf_r_q;
                        buf_full_d = 1'b0;
                    end else begin
                        urun_d = 1'b1;
                        if (underrun_cnt_out != '1) ucnt_d = underrun_cnt_out + 1'b1;
`ifdef I2S_TX_CTRL_REPEAT_EN
`else
                        pl_d = '0;
                        pr_d = '0;
`endif
                        // A pair arriving on this very cycle only fills the buffer for the next frame.
                        if (accept) begin
                            buf_full_d = 1'b1;
                            buf_l_d    = s_ldata_in;
                            buf_r_d    = s_rdata_in;
                        end
                    end
                end else if (accept) begin
                    buf_full_d = 1'b1;
                    buf_l_d    = s_ldata_in;
                    buf_r_d    = s_rdata_in;
                end
            end
            default: begin
                state_d    = IDLE;
                buf_full_d = 1'b0;
            end
        endcase

        ready_d = (state_d != IDLE) && !buf_full_d;
        lrck_d  = (state_d == RUN) && half;
    end

    always_ff @(posedge sclk_in) begin
        if (rst) begin
            state_q          <= IDLE;
            buf_full_q       <= 1'b0;
            buf_l_q          <= '0;
            buf_r_q          <= '0;
            pldata_out       <= '0;
            prdata_out       <= '0;
            s_ready_out      <= 1'b0;
            lrck_out         <= 1'b0;
            underrun_out     <= 1'b0;
            underrun_cnt_out <= '0;
        end else begin
            state_q          <= state_d;
            buf_full_q       <= buf_full_d;
            buf_l_q          <= buf_l_d;
            buf_r_q          <= buf_r_d;
            pldata_out       <= pl_d;
            prdata_out       <= pr_d;
            s_ready_out      <= ready_d;
            lrck_out         <= lrck_d;
            underrun_out     <= urun_d;
            underrun_cnt_out <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: directed phases plus randomized valid/data against a
// queue-based frame model; honours I2S_TX_CTRL_REPEAT_EN when defined.
module tb_i2s_tx_ctrl;

    localparam int W     = 32;
    localparam int FRAME = 2 * W;

    logic          sclk_in = 1'b0;
    logic          rst, enable_in, s_valid_in;
    logic          s_ready_out, lrck_out, underrun_out;
    logic [W-1:0]  s_ldata_in, s_rdata_in, pldata_out, prdata_out;
    logic [15:0]   underrun_cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: run mode, frame position, a one-deep pending-pair queue and the visible outputs.
    int            m_mode;   // 0 stopped, 1 priming, 2 running
    int            m_pos;
    logic [63:0]   m_q[$];
    logic [W-1:0]  m_l, m_r;
    logic          m_lr, m_rdy, m_urun;
    int            m_ucnt;
    logic          took;
    int            k;

    i2s_tx_ctrl #(.pdata_width(W)) dut (
        .sclk_in          (sclk_in),
        .rst              (rst),
        .enable_in        (enable_in),
        .s_valid_in       (s_valid_in),
        .s_ready_out      (s_ready_out),
        .s_ldata_in       (s_ldata_in),
        .s_rdata_in       (s_rdata_in),
        .lrck_out         (lrck_out),
        .pldata_out       (pldata_out),
        .prdata_out       (prdata_out),
        .underrun_out     (underrun_out),
        .underrun_cnt_out (underrun_cnt_out)
    );

    always #5 sclk_in = ~sclk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_to_out();
        logic [63:0] p;
        p   = m_q.pop_front();
        m_l = p[63:32];
        m_r = p[31:0];
    endtask

    task automatic model_edge();
        logic acc;
        int   prev_pos;
        acc      = s_valid_in && m_rdy;
        prev_pos = m_pos;
        m_urun   = 1'b0;
        took     = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_q.delete();
            m_l = '0; m_r = '0; m_lr = 1'b0; m_rdy = 1'b0; m_ucnt = 0;
            return;
        end
        took = acc;
        case (m_mode)
            0: if (enable_in) m_mode = 1;
            1: begin
                if (!enable_in) begin
                    m_mode = 0; m_q.delete();
                end else if (m_q.size() != 0) begin
                    m_mode = 2; m_pos = 0; pop_to_out();
                end else if (acc) begin
                    m_q.push_back({s_ldata_in, s_rdata_in});
                end
            end
            default: begin
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (!enable_in) begin
                        m_mode = 0; m_q.delete();
                    end else if (m_q.size() != 0) begin
                        pop_to_out();
                    end else begin
                        m_urun = 1'b1;
                        if (m_ucnt < 65535) m_ucnt++;
`ifndef I2S_TX_CTRL_REPEAT_EN
                        m_l = '0; m_r = '0;
`endif
                        if (acc) m_q.push_back({s_ldata_in, s_rdata_in});
                    end
                end else begin
                    m_pos++;
                    if (acc) m_q.push_back({s_ldata_in, s_rdata_in});
                end
            end
        endcase
        // Word select shows the half the previous cycle was in, and is low whenever not running.
        m_lr  = (m_mode == 2) && (prev_pos >= W);
        m_rdy = (m_mode != 0) && (m_q.size() == 0);
    endtask

    task automatic tick();
        @(posedge sclk_in);
        model_edge();
        #1;
        check("lrck",     32'(lrck_out),         32'(m_lr));
        check("ready",    32'(s_ready_out),      32'(m_rdy));
        check("underrun", 32'(underrun_out),     32'(m_urun));
        check("ucnt",     32'(underrun_cnt_out), 32'(m_ucnt));
        check("pldata",   pldata_out,            m_l);
        check("prdata",   prdata_out,            m_r);
    endtask

    // vmode: 0 valid low, 1 valid high with incrementing pairs, 2 sparse random valid with random data
    task automatic drive(input int vmode);
        case (vmode)
            0:       s_valid_in = 1'b0;
            1:       s_valid_in = 1'b1;
            default: s_valid_in = ($urandom_range(0, 39) == 0);
        endcase
    endtask

    task automatic advance(input int vmode);
        if (took) begin
            k++;
            if (vmode == 2) begin
                s_ldata_in = $urandom;
                s_rdata_in = $urandom;
            end else begin
                s_ldata_in = 32'h1000_0000 + k;
                s_rdata_in = 32'h2000_0000 + k;
            end
        end
    endtask

    task automatic step(input int vmode);
        drive(vmode);
        tick();
        advance(vmode);
    endtask

    task automatic wait_pos(input int p, input int vmode);
        int n;
        n = 0;
        do begin
            step(vmode);
            n++;
        end while (!(m_mode == 2 && m_pos == p) && n < 1000);
        if (n >= 1000) begin
            n_checks++;
            n_errors++;
            $error("FAIL wait_pos_timeout observed=%0d expected=%0d", m_pos, p);
        end
    endtask

    initial begin
        int          n;
        int          lr_hi, rdy_hi;
        logic [31:0] prev_l;

        k = 0;
        m_mode = 0; m_pos = 0; m_l = '0; m_r = '0; m_lr = 1'b0; m_rdy = 1'b0; m_ucnt = 0;
        rst = 1'b1; enable_in = 1'b0; s_valid_in = 1'b0;
        s_ldata_in = 32'hA5A5_A5A5; s_rdata_in = 32'h5A5A_5A5A;
        repeat (3) step(0);
        check("reset_l", pldata_out, 32'h0);
        check("reset_ready", 32'(s_ready_out), 32'h0);

        // Start-up with the reference pair, then continuous incrementing pairs.
        rst = 1'b0;
        enable_in = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (m_mode != 2 && n < 50);
        check("start_l", pldata_out, 32'hA5A5_A5A5);
        check("start_r", prdata_out, 32'h5A5A_5A5A);

        lr_hi = 0; rdy_hi = 0;
        repeat (FRAME) begin
            step(1);
            lr_hi  += int'(lrck_out);
            rdy_hi += int'(s_ready_out);
        end
        check("lrck_high_cycles", 32'(lr_hi), 32'd32);
        check("ready_per_frame", 32'(rdy_hi), 32'd1);

        wait_pos(0, 1);
        wait_pos(0, 1);
        check("no_underrun_cont", 32'(underrun_cnt_out), 32'd0);

        // Withhold valid for a whole frame.
        prev_l = m_l;
        wait_pos(0, 0);
        check("underrun_pulse", 32'(underrun_out), 32'd1);
        check("underrun_cnt1", 32'(underrun_cnt_out), 32'd1);
`ifdef I2S_TX_CTRL_REPEAT_EN
        check("underrun_data", pldata_out, prev_l);
`else
        check("underrun_data", pldata_out, 32'h0);
`endif
        step(0);
        check("underrun_one_cycle", 32'(underrun_out), 32'd0);

        // Pair accepted exactly on the boundary cycle with the buffer empty.
        wait_pos(FRAME - 1, 0);
        s_ldata_in = 32'hC0FF_EE01;
        s_rdata_in = 32'hC0FF_EE02;
        s_valid_in = 1'b1;
        tick();
        advance(1);
        check("bnd_underrun_cnt", 32'(underrun_cnt_out), 32'd2);
        wait_pos(0, 0);
        check("bnd_pair_l", pldata_out, 32'hC0FF_EE01);
        check("bnd_pair_r", prdata_out, 32'hC0FF_EE02);
        check("bnd_no_new_underrun", 32'(underrun_cnt_out), 32'd2);

        // Randomized sparse traffic with random data.
        repeat (8 * FRAME) step(2);

        // Stop request mid-frame: the frame runs to its end before going idle.
        wait_pos(10, 1);
        enable_in = 1'b0;
        n = 0;
        while (m_mode != 0 && n < 200) begin
            step(1);
            n++;
        end
        check("stop_cycles", 32'(n), 32'd54);
        check("stop_lrck", 32'(lrck_out), 32'd0);
        check("stop_ready", 32'(s_ready_out), 32'd0);
        repeat (5) step(1);

        // Abort while priming.
        enable_in = 1'b1;
        step(0);
        enable_in = 1'b0;
        step(0);
        step(0);
        check("prime_abort_ready", 32'(s_ready_out), 32'd0);

        // Restart, then reset in the middle of a frame.
        enable_in = 1'b1;
        wait_pos(0, 1);
        wait_pos(40, 2);
        rst = 1'b1;
        step(1);
        check("rst_lrck", 32'(lrck_out), 32'd0);
        check("rst_ready", 32'(s_ready_out), 32'd0);
        check("rst_urun", 32'(underrun_out), 32'd0);
        check("rst_ucnt", 32'(underrun_cnt_out), 32'd0);
        check("rst_l", pldata_out, 32'h0);
        check("rst_r", prdata_out, 32'h0);
        rst = 1'b0;
        repeat (2 * FRAME) step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
